// File: rtl/branch_pred_unit_if.sv
// branch_pred_unit_if: fetch/execute/redirect signal bundle of the branch prediction unit.
// master = pipeline side, slave = branch_pred_unit.
interface branch_pred_unit_if #(
   parameter int PC_WIDTH = 32
);
   logic                if_valid;
   logic [PC_WIDTH-1:0] if_pc;
   logic                if_is_branch;
   logic                pred_taken;
   logic                jal_id;
   logic                ex_valid;
   logic [PC_WIDTH-1:0] ex_pc;
   logic [2:0]          ex_funct3;
   logic                ex_is_branch;
   logic                ex_is_jalr;
   logic                ex_pred_taken;
   logic                BrEq;
   logic                BrLt;
   logic [2:0]          PCSel;
   logic                flush;
   logic [31:0]         perf_branches;
   logic [31:0]         perf_mispredicts;

   modport master (
      output if_valid, if_pc, if_is_branch, jal_id, ex_valid, ex_pc, ex_funct3,
             ex_is_branch, ex_is_jalr, ex_pred_taken, BrEq, BrLt,
      input  pred_taken, PCSel, flush, perf_branches, perf_mispredicts
   );

   modport slave (
      input  if_valid, if_pc, if_is_branch, jal_id, ex_valid, ex_pc, ex_funct3,
             ex_is_branch, ex_is_jalr, ex_pred_taken, BrEq, BrLt,
      output pred_taken, PCSel, flush, perf_branches, perf_mispredicts
   );
endinterface

// File: rtl/branch_pred_unit.sv
// branch_pred_unit: direct-mapped 2-bit counter predictor with next-PC select and mispredict flush.
// Define BP_PERF_CNT_EN to build the resolved-branch / mispredict counters.
module branch_pred_unit #(
   parameter int         PC_WIDTH = 32,
   parameter int         ENTRIES  = 64,
   parameter logic [1:0] CTR_INIT = 2'b01
) (
   input logic          clk,
   input logic          rst_n,
   branch_pred_unit_if.slave bp
);
   localparam int IW = $clog2(ENTRIES);

   logic [1:0]    table_q [ENTRIES];
   logic [1:0]    table_d [ENTRIES];
   logic [IW-1:0] rd_idx;
   logic [IW-1:0] wr_idx;
   logic [1:0]    cur;
   logic          legal;
   logic          taken;
   logic          resolve;
   logic          mispred;
   logic          pred;
   logic [2:0]    pc_sel;
   logic          unused_pc;

   assign unused_pc = ^{bp.if_pc, bp.ex_pc};

   always_comb begin
      rd_idx  = bp.if_pc[IW+1:2];
      wr_idx  = bp.ex_pc[IW+1:2];
      legal   = bp.ex_funct3[2:1] != 2'b01;
      // funct3[0] inverts the sense: BEQ/BNE on BrEq, BLT(U)/BGE(U) on BrLt
      taken   = bp.ex_funct3[2] ? bp.BrLt ^ bp.ex_funct3[0]
                                : ~bp.ex_funct3[1] & (bp.BrEq ^ bp.ex_funct3[0]);
      resolve = bp.ex_valid & bp.ex_is_branch & legal;
      mispred = resolve & (taken != bp.ex_pred_taken);
      pred    = bp.if_valid & bp.if_is_branch & table_q[rd_idx][1];
      pc_sel  = ((mispred & taken) | (bp.ex_valid & bp.ex_is_jalr)) ? 3'd2 :
                mispred   ? 3'd3 :
                bp.jal_id ? 3'd1 :
                pred      ? 3'd4 : 3'd0;
      bp.pred_taken = pred;
      bp.PCSel      = pc_sel;
      bp.flush      = pc_sel == 3'd2 || pc_sel == 3'd3;
      cur     = table_q[wr_idx];
      table_d = table_q;
      if (resolve)
         table_d[wr_idx] = taken ? (cur == 2'b11 ? cur : cur + 2'd1)
                                 : (cur == 2'b00 ? cur : cur - 2'd1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         for (int i = 0; i < ENTRIES; i++) table_q[i] <= CTR_INIT;
      else
         table_q <= table_d;
   end

`ifdef BP_PERF_CNT_EN
   logic [31:0] perf_branches_q, perf_branches_d;
   logic [31:0] perf_mispredicts_q, perf_mispredicts_d;

   always_comb begin
      perf_branches_d     = perf_branches_q + {31'd0, resolve};
      perf_mispredicts_d  = perf_mispredicts_q + {31'd0, mispred};
      bp.perf_branches    = perf_branches_q;
      bp.perf_mispredicts = perf_mispredicts_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         perf_branches_q    <= '0;
         perf_mispredicts_q <= '0;
      end else begin
         perf_branches_q    <= perf_branches_d;
         perf_mispredicts_q <= perf_mispredicts_d;
      end
   end
`else
   always_comb begin
      bp.perf_branches    = '0;
      bp.perf_mispredicts = '0;
   end
`endif
endmodule

// File: doc/branch_pred_unit.md
# branch_pred_unit

Parametrised successor to the pipeline's next-PC selection logic. The block adds a direct-mapped table of 2-bit saturating counters. The table is indexed by fetch PC and predicts conditional branches at fetch. Branches resolve in execute using `BrEq`/`BrLt`, the table trains on each resolved branch, and the block drives the widened `PCSel` mux plus a flush on mispredict. It sits between the fetch PC register and the execute-stage branch comparator.

## Interface
- `PC_WIDTH`, 32: PC width in bits.
- `ENTRIES`, 64: counter-table depth; power of two, ≥2.
- `CTR_INIT`, 2'b01: counter value loaded on reset.

- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: reset; synchronous and active-low.
- `if_valid` in 1: fetch PC valid.
- `if_pc` in `PC_WIDTH`: fetch PC.
- `if_is_branch` in 1: predecode says the fetched instruction is a conditional branch.
- `pred_taken` out 1: fetch-stage prediction; the pipeline carries it to execute.
- `jal_id` in 1: JAL decoded in the ID stage.
- `ex_valid` in 1: execute-stage instruction valid.
- `ex_pc` in `PC_WIDTH`: execute-stage PC.
- `ex_funct3` in 3: execute-stage funct3.
- `ex_is_branch` in 1: execute-stage instruction is a conditional branch.
- `ex_is_jalr` in 1: execute-stage instruction is JALR.
- `ex_pred_taken` in 1: prediction that was made for the execute-stage instruction.
- `BrEq` in 1: comparator equal result.
- `BrLt` in 1: comparator less-than result; signedness is selected upstream.
- `PCSel` out 3: next-PC source select.
- `flush` out 1: kill the IF and ID instructions.
- `perf_branches` out 32: count of resolved branches; only when `BP_PERF_CNT_EN` is defined.
- `perf_mispredicts` out 32: count of mispredicted branches; only when `BP_PERF_CNT_EN` is defined.

## Operation
- Index: `idx = pc[log2(ENTRIES)+1:2]`.
- Counter encoding:
  - 00 = strong not-taken, 01 = weak not-taken, 10 = weak taken, 11 = strong taken.
  - Predict taken when the MSB is 1.
- `pred_taken = if_valid & if_is_branch & table[idx(if_pc)][1]`. This is a combinational read.
- Actual outcome `taken`, decoded from `ex_funct3`:
  - 000 → `BrEq`
  - 001 → `~BrEq`
  - 100 and 110 → `BrLt`
  - 101 and 111 → `~BrLt`
  - 010 and 011 → not a legal branch: `taken=0`, no table update, no counter increment, no mispredict.
- `resolve = ex_valid & ex_is_branch & legal funct3`.
- Training on `resolve`: `table[idx(ex_pc)]` increments if `taken` and decrements if not, saturating at 11 and 00.
- `mispred = resolve & (taken != ex_pred_taken)`.
- `PCSel` priority, highest first:
  - 3'd2: `mispred & taken`, or `ex_valid & ex_is_jalr` (ALU target).
  - 3'd3: `mispred & ~taken` (recover to `ex_pc+4`).
  - 3'd1: `jal_id` (JAL target).
  - 3'd4: `pred_taken` (fetch-computed branch target).
  - 3'd0: otherwise (PC+4).
- `flush` = 1 exactly when `PCSel` is 2 or 3.
- A correctly predicted branch produces no redirect and no flush.

## Timing
- `pred_taken`, `PCSel` and `flush` are combinational, with no latency.
- Table updates take effect on the next rising edge.
- Same-cycle read and write of the same index: the read returns the pre-update value. There is no bypass.
- Reset (`rst_n`=0 at a rising edge):
  - Every table entry is set to `CTR_INIT` in that one cycle.
  - Both perf counters are set to 0.
  - Reset applied mid-operation discards all training.
  - The combinational outputs still follow their inputs while in reset; the pipeline gates them with its own valid bits.
- JALR in execute together with a mispredict: not possible. If both are asserted, `PCSel`=2.
- The `ex_*` and `jal_id` inputs are stable before the clock edge; the block adds no registers on the `PCSel` path.

## Configuration
- `BP_PERF_CNT_EN` defined:
  - `perf_branches` increments on each `resolve`.
  - `perf_mispredicts` increments on each `mispred`.
  - Both are 32-bit, wrap from 0xFFFFFFFF to 0, and are cleared by reset.
- `BP_PERF_CNT_EN` undefined:
  - Both ports still exist and are tied to 0.
  - No counter registers are built.

## Test plan
- Reset with `CTR_INIT`=01, then a BEQ at `if_pc`=0x100 → `pred_taken`=0. Resolve it with `BrEq`=1 and `ex_pred_taken`=0 → `PCSel`=2, `flush`=1, entry becomes 10. Next fetch of 0x100 → `pred_taken`=1.
- Resolve a BNE at 0x200 as taken four times → counter saturates at 11. One not-taken resolve with `ex_pred_taken`=1 → `PCSel`=3, `flush`=1, counter becomes 10.
- Same-cycle resolve and fetch of 0x300 with the counter at 01 and `taken`=1 → `pred_taken`=0 in that cycle and 1 in the following cycle.
- Simultaneous JALR in execute (`ex_is_jalr`=1) and `jal_id`=1 → `PCSel`=2, `flush`=1. With `ex_valid`=0 and `jal_id`=1 → `PCSel`=1.
- `ex_funct3`=010 with `ex_is_branch`=1 → no table change, no flush, perf counters unchanged.
- `BP_PERF_CNT_EN` defined, 5 resolves of which 2 mispredict → `perf_branches`=5, `perf_mispredicts`=2. Assert `rst_n`=0 for one cycle → both counters 0 and the table back to `CTR_INIT`.
